// File: rtl/hack_pkg.sv
// Shared constants and state encodings for the Hack SPI memory controller.
// The frame length helper keeps the top and the shifter in agreement on N.
package hack_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         WORD_W        = 16;
  localparam int         ADDR_W        = 15;

  // SHIFT is the only state with bit 0 set, so csb_o decodes from one bit.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } ctrl_state_t;

  function automatic int frame_bits(input int addr_bytes);
    return 8 + 8 * addr_bytes + WORD_W;
  endfunction

endpackage

// File: rtl/hack_spi_shifter.sv
// SCLK divider and frame shifter: sends an N-bit frame MSB first in SPI mode 0
// and collects the last 16 MISO bits; last_edge marks the final sampling edge.
module hack_spi_shifter
  import hack_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int N       = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      frame,
  input  logic              mi_i,
  output logic              sclk_o,
  output logic              mo_o,
  output logic              last_edge,
  output logic [WORD_W-1:0] rdata_next
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(N + 1);

  logic              active_reg;
  logic              sclk_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [N-1:0]      sh_out_reg;
  logic [WORD_W-1:0] sh_in_reg;

  logic phase_end;
  logic bit_end;

  assign phase_end  = active_reg && (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign bit_end    = phase_end && sclk_reg;
  assign last_edge  = bit_end && (bit_cnt_reg == '0);
  assign rdata_next = {sh_in_reg[WORD_W-2:0], mi_i};
  assign sclk_o     = sclk_reg;
  // Frame drains to zeros, so MOSI falls to 0 by itself after the last bit.
  assign mo_o       = sh_out_reg[N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg  <= 1'b0;
      sclk_reg    <= 1'b0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      sh_out_reg  <= '0;
      sh_in_reg   <= '0;
    end else if (start) begin
      active_reg  <= 1'b1;
      sclk_reg    <= 1'b0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= BIT_W'(N - 1);
      sh_out_reg  <= frame;
      sh_in_reg   <= '0;
    end else if (active_reg) begin
      if (phase_end) begin
        div_cnt_reg <= '0;
        sclk_reg    <= ~sclk_reg;
        if (sclk_reg) begin
          // End of the high phase: sample MISO, present the next MOSI bit.
          sh_in_reg  <= rdata_next;
          sh_out_reg <= sh_out_reg << 1;
          if (bit_cnt_reg == '0) begin
            active_reg <= 1'b0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg - BIT_W'(1);
          end
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/hack_spi_mem_ctrl.sv
// Hack core memory port to 23LC-style SPI SRAM: one word per request,
// request handshake, frame assembly and chip-select spacing between frames.
module hack_spi_mem_ctrl
  import hack_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int ADDR_BYTES = 2,
  parameter int CS_IDLE    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              sclk_o,
  output logic              csb_o,
  output logic              mo_o,
  input  logic              mi_i
);

  localparam int N    = frame_bits(ADDR_BYTES);
  localparam int AB_W = 8 * ADDR_BYTES;
  localparam int CS_W = $clog2(CS_IDLE + 1);

  ctrl_state_t       state_reg;
  ctrl_state_t       state_next;
  logic              we_reg;
  logic [CS_W-1:0]   cs_cnt_reg;
  logic              rsp_valid_reg;
  logic [WORD_W-1:0] rsp_rdata_reg;

  logic              accept;
  logic              last_edge;
  logic [N-1:0]      frame;
  logic [WORD_W-1:0] rdata_next;

  assign accept = req_valid && req_ready;
  // Word address becomes a byte address; reads clock out zeros in the data slot.
  assign frame  = {req_we ? SPI_CMD_WRITE : SPI_CMD_READ,
                   AB_W'({req_addr, 1'b0}),
                   req_we ? req_wdata : {WORD_W{1'b0}}};

  hack_spi_shifter #(
    .CLK_DIV (CLK_DIV),
    .N       (N)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .start      (accept),
    .frame      (frame),
    .mi_i       (mi_i),
    .sclk_o     (sclk_o),
    .mo_o       (mo_o),
    .last_edge  (last_edge),
    .rdata_next (rdata_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (last_edge) state_next = ST_DONE;
      ST_DONE:  if (cs_cnt_reg == CS_W'(CS_IDLE - 1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    csb_o     = 1'b1;
    case (state_reg)
      ST_IDLE:  req_ready = 1'b1;
      ST_SHIFT: csb_o     = 1'b0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg        <= 1'b0;
      cs_cnt_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      if (accept) begin
        we_reg <= req_we;
      end
      cs_cnt_reg    <= (state_reg == ST_DONE) ? cs_cnt_reg + CS_W'(1) : '0;
      rsp_valid_reg <= (state_reg == ST_SHIFT) && last_edge;
      if ((state_reg == ST_SHIFT) && last_edge && !we_reg) begin
        rsp_rdata_reg <= rdata_next;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_hack_spi_mem_ctrl.sv
// Directed bench: two controller instances (defaults, and CLK_DIV=1/3 address
// bytes) share a behavioural 23LC SRAM model selected by sel.
module tb_hack_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
  logic        mi = 1'b0;

  logic        rv_a, ready_a, rspv_a, sclk_a, csb_a, mo_a;
  logic        rv_b, ready_b, rspv_b, sclk_b, csb_b, mo_b;
  logic [15:0] rdata_a, rdata_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rv_a = req_valid & ~sel;
  assign rv_b = req_valid & sel;

  hack_spi_mem_ctrl #(.CLK_DIV(2), .ADDR_BYTES(2), .CS_IDLE(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_a), .rsp_rdata(rdata_a),
    .sclk_o(sclk_a), .csb_o(csb_a), .mo_o(mo_a), .mi_i(mi)
  );

  hack_spi_mem_ctrl #(.CLK_DIV(1), .ADDR_BYTES(3), .CS_IDLE(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_b), .rsp_rdata(rdata_b),
    .sclk_o(sclk_b), .csb_o(csb_b), .mo_o(mo_b), .mi_i(mi)
  );

  logic        cur_ready, cur_rspv, cur_sclk, cur_csb, cur_mo;
  logic [15:0] cur_rdata;
  assign cur_ready = sel ? ready_b : ready_a;
  assign cur_rspv  = sel ? rspv_b  : rspv_a;
  assign cur_sclk  = sel ? sclk_b  : sclk_a;
  assign cur_csb   = sel ? csb_b   : csb_a;
  assign cur_mo    = sel ? mo_b    : mo_a;
  assign cur_rdata = sel ? rdata_b : rdata_a;

  // SRAM model, sampled on the falling clk edge, well away from DUT updates.
  logic [15:0] mem [0:32767];
  logic        mem_init = 1'b0;
  logic        sclk_prev = 1'b0;
  logic        mo_prev = 1'b0;
  logic        is_write = 1'b0;
  logic        is_read = 1'b0;
  logic [14:0] word_addr = '0;
  logic [15:0] rd_word = '0;
  logic [63:0] rx_sr = '0;
  int          rx_cnt = 0;
  int          mo_viol = 0;
  int          hdr;
  int          nbits;
  assign hdr   = sel ? 32 : 24;
  assign nbits = sel ? 48 : 40;

  always @(negedge clk) begin
    sclk_prev <= cur_sclk;
    mo_prev   <= cur_mo;
    if (sclk_prev && cur_sclk && (cur_mo != mo_prev)) mo_viol <= mo_viol + 1;
    if (!mem_init) begin
      mem[15'h0123] <= 16'hBEEF;
      mem_init      <= 1'b1;
    end
    if (cur_csb) begin
      rx_cnt <= 0;
      mi     <= 1'b0;
    end else if (cur_sclk && !sclk_prev) begin
      rx_sr  <= (rx_cnt == 0) ? {63'b0, cur_mo} : {rx_sr[62:0], cur_mo};
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == nbits - 1 && is_write) mem[word_addr] <= {rx_sr[14:0], cur_mo};
    end else if (!cur_sclk && sclk_prev) begin
      if (rx_cnt == hdr) begin
        is_write  <= (rx_sr[hdr-1 -: 8] == 8'h02);
        is_read   <= (rx_sr[hdr-1 -: 8] == 8'h03);
        word_addr <= rx_sr[15:1];
        rd_word   <= mem[rx_sr[15:1]];
        mi        <= (rx_sr[hdr-1 -: 8] == 8'h03) ? mem[rx_sr[15:1]][15] : 1'b0;
      end else if (rx_cnt > hdr && rx_cnt < hdr + 16 && is_read) begin
        mi <= rd_word[15 - (rx_cnt - hdr)];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns one step after the accepting edge, i.e. in cycle 1.
  task automatic accept_req(input logic we, input logic [14:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!cur_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(n < 1000), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!cur_rspv && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic txn(input logic we, input logic [14:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd, input int exp_cyc, input logic [63:0] exp_frame);
    int cyc;
    accept_req(we, a, d);
    check("cyc1_csb", cur_csb, 0);
    check("cyc1_sclk", cur_sclk, 0);
    check("cyc1_mo", cur_mo, 0);
    wait_rsp(cyc);
    check("rsp_cycle", cyc, exp_cyc);
    check("rsp_rdata", cur_rdata, exp_rd);
    check("rsp_csb", cur_csb, 1);
    check("rsp_mo", cur_mo, 0);
    check("mosi_frame", rx_sr, exp_frame);
    @(posedge clk); #1;
    check("rsp_one_pulse", cur_rspv, 0);
    check("ready_cs_idle", cur_ready, 0);
    @(posedge clk); #1;
    check("ready_back", cur_ready, 1);
  endtask

  initial begin
    int cyc, ready_cyc, first_rsp, early_ready, csb_hi, stray;
    sel = 1'b0; rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

    // 1: reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_csb", csb_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_mo", mo_a, 0);
    check("rst_ready", ready_a, 1);
    check("rst_rspv", rspv_a, 0);
    check("rst_rdata", rdata_a, 0);
    check("rst_b_csb", csb_b, 1);
    rst = 1'b0;

    // 2: read 0x0123 -> BEEF; 3: write 0x7FFF, then read it back
    txn(1'b0, 15'h0123, 16'h0000, 16'hBEEF, 161, 64'h0302460000);
    txn(1'b1, 15'h7FFF, 16'hA55A, 16'hBEEF, 161, 64'h02FFFEA55A);
    check("model_write", mem[15'h7FFF], 16'hA55A);
    txn(1'b0, 15'h7FFF, 16'h0000, 16'hA55A, 161, 64'h03FFFE0000);

    // 4: request held high across two reads
    accept_req(1'b0, 15'h0123, 16'h0000);
    req_valid = 1'b1;
    req_addr  = 15'h7FFF;
    cyc = 1; ready_cyc = 0; first_rsp = 0; early_ready = 0; csb_hi = 0;
    while (cyc < 400) begin
      if (cyc <= 162 && cur_ready) early_ready++;
      if (cur_ready && ready_cyc == 0) ready_cyc = cyc;
      if (cyc >= 161 && cyc <= 163 && cur_csb) csb_hi++;
      if (cur_rspv && first_rsp == 0) begin
        first_rsp = cyc;
        check("b2b_rdata1", cur_rdata, 16'hBEEF);
      end
      if (cyc == 164) begin
        check("b2b_second_started", cur_csb, 0);
        req_valid = 1'b0;
      end
      if (cyc > 164 && cur_rspv) break;
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_rsp1_cycle", first_rsp, 161);
    check("b2b_ready_cycle", ready_cyc, 163);
    check("b2b_ready_low", early_ready, 0);
    check("b2b_csb_gap", 64'(csb_hi >= 2), 1);
    check("b2b_rsp2_cycle", cyc, 324);
    check("b2b_rdata2", cur_rdata, 16'hA55A);
    repeat (2) @(posedge clk);
    #1;

    // 5: reset during bit 20 of a read
    accept_req(1'b0, 15'h0123, 16'h0000);
    cyc = 1;
    while (cyc < 82) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_csb_low", cur_csb, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_csb", cur_csb, 1);
    check("abort_sclk", cur_sclk, 0);
    check("abort_mo", cur_mo, 0);
    check("abort_rspv", cur_rspv, 0);
    check("abort_rdata", cur_rdata, 0);
    check("abort_ready", cur_ready, 1);
    stray = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (cur_rspv) stray++;
    end
    check("abort_no_rsp", stray, 0);
    txn(1'b0, 15'h7FFF, 16'h0000, 16'hA55A, 161, 64'h03FFFE0000);

    // 6: CLK_DIV=1, three address bytes
    sel = 1'b1;
    txn(1'b0, 15'h0123, 16'h0000, 16'hBEEF, 97, 64'h030002460000);

    check("mo_stable_high", mo_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
